// File: rtl/lab7_soc_to_hw_port_if.sv
// Avalon-MM slave bus carrying register accesses into the lab7 to-hardware output port.
interface lab7_soc_to_hw_port_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/lab7_soc_to_hw_port.sv
// Memory-mapped output port: data register OR'd with a timed pulse mask, plus change strobe.
// Optional set/clear registers at addresses 2/3 are built when TO_HW_PORT_SETCLR_EN is defined.
module lab7_soc_to_hw_port #(
  parameter int unsigned WIDTH        = 8,
  parameter logic [31:0] RESET_VALUE  = 32'd0,
  parameter int unsigned PULSE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  lab7_soc_to_hw_port_if.slave        bus,
  output logic [WIDTH-1:0]            out_port,
  output logic                        out_strobe
);

  localparam logic [1:0]       AddrData  = 2'd0;
  localparam logic [1:0]       AddrMask  = 2'd1;
`ifdef TO_HW_PORT_SETCLR_EN
  localparam logic [1:0]       AddrSet   = 2'd2;
  localparam logic [1:0]       AddrClr   = 2'd3;
`endif
  localparam logic [WIDTH-1:0] ResetData = RESET_VALUE[WIDTH-1:0];
  localparam logic [15:0]      PulseLoad = 16'(PULSE_CYCLES);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] prev_out_q;
  logic             strobe_q, strobe_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             pulse_active;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign pulse_active = (cnt_q != 16'd0);

  // Bits of writedata above WIDTH-1 are deliberately dropped.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  // Register writes; a mask write reloads the counter even on its expiry cycle.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (pulse_active) begin
      cnt_d = cnt_q - 16'd1;
    end
    if (wr_en) begin
      case (bus.address)
        AddrData: data_d = wdata;
        AddrMask: begin
          mask_d = wdata;
          cnt_d  = PulseLoad;
        end
`ifdef TO_HW_PORT_SETCLR_EN
        AddrSet:  data_d = data_q | wdata;
        AddrClr:  data_d = data_q & ~wdata;
`endif
        default: ;
      endcase
    end
  end

  // Output is decoded from registers only, so no bus input reaches out_port combinationally.
  always_comb begin
    out_port = data_q | (pulse_active ? mask_q : '0);
  end

  always_comb begin
    strobe_d = (out_port != prev_out_q);
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      AddrData: readdata_d[WIDTH-1:0] = data_q;
      AddrMask: begin
        if (pulse_active) begin
          readdata_d[WIDTH-1:0] = mask_q;
        end
      end
      default: ;
    endcase
  end

  // prev_out_q resets to the post-reset output so the reset itself never strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= ResetData;
      mask_q     <= '0;
      cnt_q      <= '0;
      prev_out_q <= ResetData;
      strobe_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      prev_out_q <= out_port;
      strobe_q   <= strobe_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_strobe   = strobe_q;
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_lab7_soc_to_hw_port.sv
// Scoreboard bench for lab7_soc_to_hw_port: expected samples queued per scenario, popped per cycle.
module tb_lab7_soc_to_hw_port;
  localparam int unsigned WIDTH        = 8;
  localparam logic [31:0] RESET_VALUE  = 32'h0000_00A5;
  localparam int unsigned PULSE_CYCLES = 16;
`ifdef TO_HW_PORT_SETCLR_EN
  localparam bit SetClrEn = 1'b1;
`else
  localparam bit SetClrEn = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  out;
    logic        strobe;
    logic [31:0] rd;
    logic        chk_rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] out_port;
  logic             out_strobe;

  lab7_soc_to_hw_port_if bus ();

  lab7_soc_to_hw_port #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE),
    .PULSE_CYCLES(PULSE_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .out_port  (out_port),
    .out_strobe(out_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Sample point: negedge after the active edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
  endtask

  task automatic drive_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic settle(input int n);
    drive_idle();
    repeat (n) cycle();
  endtask

  function automatic void push(input logic [7:0] o, input logic s, input logic [31:0] r,
                               input logic c);
    exp_t t;
    t.out    = o;
    t.strobe = s;
    t.rd     = r;
    t.chk_rd = c;
    exp_q.push_back(t);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive_write(2'd0, 32'h0000_00FF);
    push(8'hA5, 1'b0, 32'h0, 1'b1);
    push(8'hA5, 1'b0, 32'h0000_00A5, 1'b1);
    push(8'hA5, 1'b0, 32'h0000_00A5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (k == 0) begin
        reset = 1'b0;
        drive_idle();
        bus.address = 2'd0;
      end
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++; $display("FAIL reset out k=%0d got %h want %h", k, out_port, e.out);
      end
      n_tests++;
      if (out_strobe !== e.strobe) begin
        n_fail++; $display("FAIL reset strobe k=%0d got %b want %b", k, out_strobe, e.strobe);
      end
      if (e.chk_rd) begin
        n_tests++;
        if (bus.readdata !== e.rd) begin
          n_fail++; $display("FAIL reset rd k=%0d got %h want %h", k, bus.readdata, e.rd);
        end
      end
    end
  endtask

  task automatic test_data_write();
    push(8'h3C, 1'b0, 32'hA5, 1'b1);
    push(8'h3C, 1'b1, 32'h3C, 1'b1);
    push(8'h3C, 1'b0, 32'h3C, 1'b1);
    push(8'h3C, 1'b0, 32'h3C, 1'b1);
    push(8'h3C, 1'b0, 32'h3C, 1'b1);
    push(8'h3C, 1'b0, 32'h3C, 1'b1);
    drive_write(2'd0, 32'hFFFF_FF3C);
    for (int k = 0; k < 6; k++) begin
      cycle();
      drive_idle();
      if (k == 2) drive_write(2'd0, 32'h0000_003C);
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++; $display("FAIL data_write out k=%0d got %h want %h", k, out_port, e.out);
      end
      n_tests++;
      if (out_strobe !== e.strobe) begin
        n_fail++;
        $display("FAIL data_write strobe k=%0d got %b want %b", k, out_strobe, e.strobe);
      end
      if (e.chk_rd) begin
        n_tests++;
        if (bus.readdata !== e.rd) begin
          n_fail++; $display("FAIL data_write rd k=%0d got %h want %h", k, bus.readdata, e.rd);
        end
      end
    end
  endtask

  task automatic test_pulse();
    drive_write(2'd0, 32'h01);
    cycle();
    settle(3);
    for (int k = 0; k < 18; k++) begin
      push((k < 16) ? 8'h81 : 8'h01, (k == 1 || k == 17),
           (k >= 1 && k <= 16) ? 32'h80 : 32'h0, 1'b1);
    end
    drive_write(2'd1, 32'h80);
    for (int k = 0; k < 18; k++) begin
      cycle();
      if (k == 0) drive_idle();
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++; $display("FAIL pulse out k=%0d got %h want %h", k, out_port, e.out);
      end
      n_tests++;
      if (out_strobe !== e.strobe) begin
        n_fail++; $display("FAIL pulse strobe k=%0d got %b want %b", k, out_strobe, e.strobe);
      end
      if (e.chk_rd) begin
        n_tests++;
        if (bus.readdata !== e.rd) begin
          n_fail++; $display("FAIL pulse rd k=%0d got %h want %h", k, bus.readdata, e.rd);
        end
      end
    end
  endtask

  task automatic test_restart();
    settle(3);
    // Restart at cycle 10 with a new mask.
    for (int k = 0; k < 28; k++) begin
      push((k < 10) ? 8'h81 : (k < 26) ? 8'h03 : 8'h01, (k == 1 || k == 11 || k == 27),
           (k == 0) ? 32'h0 : (k <= 10) ? 32'h80 : (k <= 26) ? 32'h02 : 32'h0, 1'b1);
    end
    // Restart exactly on the expiry edge.
    for (int k = 0; k < 34; k++) begin
      push((k < 16) ? 8'h05 : (k < 32) ? 8'h09 : 8'h01, (k == 1 || k == 17 || k == 33),
           (k == 0) ? 32'h0 : (k <= 16) ? 32'h04 : (k <= 32) ? 32'h08 : 32'h0, 1'b1);
    end
    drive_write(2'd1, 32'h80);
    for (int k = 0; k < 62; k++) begin
      cycle();
      if (k == 0 || k == 10 || k == 28 || k == 44) drive_idle();
      if (k == 9) drive_write(2'd1, 32'h02);
      if (k == 27) drive_write(2'd1, 32'h04);
      if (k == 43) drive_write(2'd1, 32'h08);
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++; $display("FAIL restart out k=%0d got %h want %h", k, out_port, e.out);
      end
      n_tests++;
      if (out_strobe !== e.strobe) begin
        n_fail++; $display("FAIL restart strobe k=%0d got %b want %b", k, out_strobe, e.strobe);
      end
      if (e.chk_rd) begin
        n_tests++;
        if (bus.readdata !== e.rd) begin
          n_fail++; $display("FAIL restart rd k=%0d got %h want %h", k, bus.readdata, e.rd);
        end
      end
    end
  endtask

  task automatic test_zero_mask();
    settle(3);
    for (int k = 0; k < 23; k++) begin
      push((k < 5) ? 8'h81 : 8'h01, (k == 1 || k == 6),
           (k >= 1 && k <= 5) ? 32'h80 : 32'h0, 1'b1);
    end
    drive_write(2'd1, 32'h80);
    for (int k = 0; k < 23; k++) begin
      cycle();
      if (k == 0 || k == 5) drive_idle();
      if (k == 4) drive_write(2'd1, 32'hFFFF_FF00);
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++; $display("FAIL zero_mask out k=%0d got %h want %h", k, out_port, e.out);
      end
      n_tests++;
      if (out_strobe !== e.strobe) begin
        n_fail++;
        $display("FAIL zero_mask strobe k=%0d got %b want %b", k, out_strobe, e.strobe);
      end
      if (e.chk_rd) begin
        n_tests++;
        if (bus.readdata !== e.rd) begin
          n_fail++; $display("FAIL zero_mask rd k=%0d got %h want %h", k, bus.readdata, e.rd);
        end
      end
    end
  endtask

  task automatic test_combine();
    settle(3);
    for (int k = 0; k < 19; k++) begin
      push((k < 5) ? 8'h81 : (k < 16) ? 8'h90 : 8'h10, (k == 1 || k == 6 || k == 17),
           32'h0, 1'b0);
    end
    drive_write(2'd1, 32'h80);
    for (int k = 0; k < 19; k++) begin
      cycle();
      if (k == 0 || k == 5) drive_idle();
      if (k == 4) drive_write(2'd0, 32'h10);
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++; $display("FAIL combine out k=%0d got %h want %h", k, out_port, e.out);
      end
      n_tests++;
      if (out_strobe !== e.strobe) begin
        n_fail++; $display("FAIL combine strobe k=%0d got %b want %b", k, out_strobe, e.strobe);
      end
    end
  endtask

  task automatic test_setclr();
    logic [7:0] after_set;
    logic [7:0] after_clr;
    after_set = SetClrEn ? 8'hFF : 8'hF0;
    after_clr = SetClrEn ? 8'h7E : 8'hF0;
    drive_write(2'd0, 32'hF0);
    cycle();
    settle(3);
    push(after_set, 1'b0, 32'h0, 1'b0);
    push(after_set, SetClrEn, 32'h0, 1'b0);
    push(after_set, 1'b0, 32'h0, 1'b0);
    push(after_clr, 1'b0, 32'h0, 1'b0);
    push(after_clr, SetClrEn, 32'h0, 1'b0);
    push(after_clr, 1'b0, 32'h0, 1'b1);
    drive_write(2'd2, 32'h0F);
    for (int k = 0; k < 6; k++) begin
      cycle();
      drive_idle();
      if (k == 2) drive_write(2'd3, 32'h81);
      if (k == 4) bus.address = 2'd0;
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++; $display("FAIL setclr out k=%0d got %h want %h", k, out_port, e.out);
      end
      n_tests++;
      if (out_strobe !== e.strobe) begin
        n_fail++; $display("FAIL setclr strobe k=%0d got %b want %b", k, out_strobe, e.strobe);
      end
      if (e.chk_rd) begin
        n_tests++;
        if (bus.readdata !== {24'h0, after_clr}) begin
          n_fail++;
          $display("FAIL setclr rd k=%0d got %h want %h", k, bus.readdata, {24'h0, after_clr});
        end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    drive_write(2'd0, 32'h3C);
    cycle();
    settle(3);
    for (int k = 0; k < 21; k++) begin
      push((k < 5) ? 8'hBC : 8'hA5, (k == 1),
           (k == 0 || k == 5) ? 32'h0 : (k < 5) ? 32'h80 : 32'hA5, 1'b1);
    end
    drive_write(2'd1, 32'h80);
    for (int k = 0; k < 21; k++) begin
      cycle();
      if (k == 0) drive_idle();
      if (k == 4) begin
        reset = 1'b1;
        drive_write(2'd0, 32'hFF);
      end
      if (k == 5) begin
        reset = 1'b0;
        drive_idle();
      end
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++; $display("FAIL reset_mid_pulse out k=%0d got %h want %h", k, out_port, e.out);
      end
      n_tests++;
      if (out_strobe !== e.strobe) begin
        n_fail++;
        $display("FAIL reset_mid_pulse strobe k=%0d got %b want %b", k, out_strobe, e.strobe);
      end
      if (e.chk_rd) begin
        n_tests++;
        if (bus.readdata !== e.rd) begin
          n_fail++;
          $display("FAIL reset_mid_pulse rd k=%0d got %h want %h", k, bus.readdata, e.rd);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'h11;
    vals[1] = 8'h22;
    vals[2] = 8'h33;
    settle(2);
    push(8'h11, 1'b0, 32'hA5, 1'b1);
    push(8'h22, 1'b1, 32'h11, 1'b1);
    push(8'h33, 1'b1, 32'h22, 1'b1);
    push(8'h33, 1'b1, 32'h33, 1'b1);
    push(8'h33, 1'b0, 32'h33, 1'b1);
    drive_write(2'd0, {24'h0, vals[0]});
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k < 2) drive_write(2'd0, {24'h0, vals[k+1]});
      else drive_idle();
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++; $display("FAIL back_to_back out k=%0d got %h want %h", k, out_port, e.out);
      end
      n_tests++;
      if (out_strobe !== e.strobe) begin
        n_fail++;
        $display("FAIL back_to_back strobe k=%0d got %b want %b", k, out_strobe, e.strobe);
      end
      if (e.chk_rd) begin
        n_tests++;
        if (bus.readdata !== e.rd) begin
          n_fail++; $display("FAIL back_to_back rd k=%0d got %h want %h", k, bus.readdata, e.rd);
        end
      end
    end
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    test_reset();
    test_data_write();
    test_pulse();
    test_restart();
    test_zero_mask();
    test_combine();
    test_setclr();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lab7_soc_to_hw_port.md
LAB7_SOC_TO_HW_PORT -- requirements
Module: lab7_soc_to_hw_port

Interface
- REQ-001: Parameter WIDTH SHALL default to 8 and set the out_port width; legal range 1..32.
- REQ-002: Parameter RESET_VALUE SHALL default to 0 and give the data register's value after reset.
- REQ-003: Parameter PULSE_CYCLES SHALL default to 16 and give the pulse duration in clk cycles; legal range 1..65535.
- REQ-004: clk  input  1  single clock; all state SHALL change on its rising edge only.
- REQ-005: reset  input  1  reset, synchronous and active-high.
- REQ-006: address  input  2  Avalon-MM slave word address.
- REQ-007: chipselect  input  1  slave select, active-high.
- REQ-008: write_n  input  1  write strobe, active-low; a write SHALL occur only when chipselect=1 and write_n=0.
- REQ-009: writedata  input  32  write data; bits above WIDTH-1 SHALL be ignored.
- REQ-010: readdata  output  32  registered read data, zero-extended above WIDTH-1.
- REQ-011: out_port  output  WIDTH  value driven to hardware.
- REQ-012: out_strobe  output  1  one-cycle pulse on every change of out_port.

Function
- REQ-013: The register map SHALL be: 0 = data (RW), 1 = pulse mask (RW), 2 = outset (WO), 3 = outclear (WO).
- REQ-014: A write to address 0 SHALL load data_reg on the following edge.
- REQ-015: A write to address 1 SHALL load pulse_mask, load pulse_cnt with PULSE_CYCLES, and set the pulse active; this SHALL happen even while a pulse is already active (restart, mask replaced).
- REQ-016: While pulse_cnt is nonzero it SHALL decrement by 1 each cycle; a pulse SHALL be active exactly PULSE_CYCLES cycles after the write edge.
- REQ-017: A write to address 1 in the same cycle that pulse_cnt reaches 0 SHALL restart the pulse; the write SHALL win.
- REQ-018: A write to address 1 with writedata[WIDTH-1:0]=0 SHALL still load the counter; out_port SHALL be unaffected.
- REQ-019: out_port SHALL equal data_reg OR (pulse_mask when the pulse is active, else 0); it SHALL be a function of registers only, with no combinational path from the bus inputs.
- REQ-020: out_strobe SHALL be 1 in the cycle after any cycle in which out_port differed from its previous-cycle value, and 0 otherwise.
- REQ-021: readdata SHALL update every cycle, independent of chipselect, with 1-cycle latency.
  - address 0: data_reg.
  - address 1: pulse_mask while the pulse is active, else 0.
  - addresses 2 and 3: 0.
- REQ-022: A data write and an active pulse SHALL combine per REQ-019 with no loss of either.

Reset
- REQ-023: On a reset edge the following SHALL hold:
  - data_reg = RESET_VALUE;
  - pulse_mask = 0, pulse_cnt = 0;
  - readdata = 0, out_strobe = 0;
  - out_port = RESET_VALUE from the next cycle.
- REQ-024: Reset SHALL override a simultaneous write and SHALL abort an in-progress pulse immediately.
- REQ-025: The change of out_port caused by reset SHALL NOT assert out_strobe.

Configuration
- REQ-026: With macro TO_HW_PORT_SETCLR_EN defined:
  - a write to address 2 SHALL do data_reg <= data_reg | writedata;
  - a write to address 3 SHALL do data_reg <= data_reg & ~writedata.
- REQ-027: Without TO_HW_PORT_SETCLR_EN, writes to addresses 2 and 3 SHALL be ignored and the set/clear logic SHALL be absent.

Verification
- REQ-028: Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0, out_strobe=0; then read address 0 -> readdata=32'h000000A5 one cycle later.
- REQ-029: Write 8'h3C to address 0 -> out_port=8'h3C on the next cycle, out_strobe=1 for exactly one cycle; write 8'h3C again -> out_strobe stays 0.
- REQ-030: data=8'h01, write 8'h80 to address 1, PULSE_CYCLES=16 -> out_port=8'h81 for 16 cycles, then 8'h01; out_strobe pulses at both transitions.
- REQ-031: Rewrite 8'h02 to address 1 at cycle 10 of a pulse -> mask becomes 8'h02 and the pulse lasts 16 cycles from the rewrite; also rewrite exactly on the expiry cycle -> no gap in the pulse.
- REQ-032: With TO_HW_PORT_SETCLR_EN, data=8'hF0, write 8'h0F to address 2 -> 8'hFF, then write 8'h81 to address 3 -> 8'h7E; without the macro, data stays 8'hF0.
- REQ-033: Assert reset at cycle 5 of a pulse, together with a write of 8'hFF to address 0 -> out_port=RESET_VALUE, pulse dead, write discarded.
